// File: rtl/half_subtractor.sv
// Registered one-bit half subtractor: d = x ^ y, b = ~x & y, one cycle after in_valid.
// Define HALF_SUBTRACTOR_BORROW_CNT_EN to add the saturating borrow_cnt debug counter.
module half_subtractor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x,
  input  logic             y,
  output logic             d,
  output logic             b,
  output logic             out_valid
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  ,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  logic d_q, d_d;
  logic b_q, b_d;
  logic out_valid_q, out_valid_d;

  // Reject counter widths outside 1..32 at elaboration.
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("half_subtractor: CNT_W must be in 1..32");
  end

  // Next-state for the result registers; x/y are only looked at when in_valid is high.
  always_comb begin
    d_d         = d_q;
    b_d         = b_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      d_d         = x ^ y;
      b_d         = ~x & y;
      out_valid_d = 1'b1;
    end else begin
      d_d         = d_q;
      b_d         = b_q;
      out_valid_d = 1'b0;
    end
  end

  // Result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= 1'b0;
      b_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      d_q         <= d_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d         = d_q;
  assign b         = b_q;
  assign out_valid = out_valid_q;

`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count accepted borrows, sticking at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (~x & y) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, updated on the same edge as b.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_subtractor.sv
// Directed self-checking bench for half_subtractor; borrow_cnt checks apply only
// when HALF_SUBTRACTOR_BORROW_CNT_EN is defined (counter built with CNT_W=2).
module tb_half_subtractor;

  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;
  logic in_valid;
  logic x;
  logic y;
  logic d;
  logic b;
  logic out_valid;
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
  logic [CNT_W-1:0] borrow_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  half_subtractor #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .d         (d),
    .b         (b),
    .out_valid (out_valid)
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    ,
    .borrow_cnt(borrow_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply inputs, clock once, then sample 1 ns after the edge.
  task automatic step(input logic r, input logic iv, input logic xi, input logic yi);
    rst      = r;
    in_valid = iv;
    x        = xi;
    y        = yi;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ed, input logic eb, input logic ev);
    check_eq({tag, ".d"}, {31'd0, d}, {31'd0, ed});
    check_eq({tag, ".b"}, {31'd0, b}, {31'd0, eb});
    check_eq({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef HALF_SUBTRACTOR_BORROW_CNT_EN
    check_eq({tag, ".borrow_cnt"}, 32'(borrow_cnt), 32'(exp));
`else
    if (exp < 0) $display("unexpected negative count for %s", tag);
`endif
  endtask

  // Directed vectors: {x, y, expected d, expected b, expected count}
  typedef struct { logic xi; logic yi; logic ed; logic eb; int ecnt; } vec_t;

  initial begin
    vec_t tbl [4];
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; x = 1'b0; y = 1'b0;
    @(negedge clk);

    // Reset held with a borrowing pair offered
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check_outs($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0);
      check_cnt($sformatf("reset%0d", i), 0);
    end

    // Exhaustive table, back to back; first pair lands on first edge with rst=0
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, tbl[i].xi, tbl[i].yi);
      check_outs($sformatf("table%0d", i), tbl[i].ed, tbl[i].eb, 1'b1);
      check_cnt($sformatf("table%0d", i), tbl[i].ecnt);
    end

    // Hold on idle: (0,1) then three idle cycles with junk on x/y
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_outs("hold_acc", 1'b1, 1'b1, 1'b1);
    check_cnt("hold_acc", 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'bx, 1'bx);
      check_outs($sformatf("hold_idle%0d", i), 1'b1, 1'b1, 1'b0);
      check_cnt($sformatf("hold_idle%0d", i), 2);
    end

    // Reset mid-stream discards the pair sampled on the reset edge
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_outs("mid_acc", 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0);
    check_cnt("mid_rst", 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("mid_after", 1'b0, 1'b0, 1'b0);
    check_cnt("mid_after", 0);

    // Saturation with CNT_W=2: 1, 2, 3, 3, 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check_outs($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b1);
      check_cnt($sformatf("sat%0d", i), (i < 3) ? i + 1 : 3);
    end

    // Non-borrowing pair after saturation leaves the counter pinned
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_outs("post_sat", 1'b0, 1'b0, 1'b1);
    check_cnt("post_sat", 3);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_outs("post_sat_idle", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/half_subtractor.md
# half_subtractor

Registered one-bit half subtractor. It computes difference D = x XOR y and borrow B = (NOT x) AND y for each accepted input pair. Results are presented one clock later with a valid strobe. It is the single-bit leaf of the subtractor datapath and feeds full-subtractor and ripple-borrow stages. An optional saturating borrow-event counter supports debug and coverage.

## Interface
- Parameters:
- CNT_W, default 8: width of the borrow-event counter. Legal range 1..32. Used only when the counter is compiled in.
- Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  qualifies x and y in the current cycle.
- x  input  1  minuend bit.
- y  input  1  subtrahend bit.
- d  output  1  registered difference, x XOR y.
- b  output  1  registered borrow, (NOT x) AND y.
- out_valid  output  1  high for exactly one cycle per accepted input pair.
- borrow_cnt  output  CNT_W  saturating count of accepted pairs with b=1. Present only with HALF_SUBTRACTOR_BORROW_CNT_EN.

## Operation
- Truth table for accepted pairs (x,y -> d,b): 0,0 -> 0,0; 0,1 -> 1,1; 1,0 -> 1,0; 1,1 -> 0,0.
- On a clock edge with rst=1:
  - d, b and out_valid go to 0.
  - borrow_cnt goes to 0.
  - in_valid is ignored in that cycle.
- On a clock edge with rst=0 and in_valid=1:
  - d <= x ^ y and b <= ~x & y.
  - out_valid <= 1.
- On a clock edge with rst=0 and in_valid=0:
  - out_valid <= 0.
  - d and b hold their last values, so downstream must qualify them with out_valid.
- No backpressure. One pair can be accepted every cycle with no stalls or bubbles.
- Borrow counter:
  - Increments by 1 on each accepted pair where ~x & y = 1.
  - Saturates at 2^CNT_W - 1, holding there with no wrap until reset.
- X or Z on x or y while in_valid=0 must not propagate into d or b.

## Timing
- Latency: exactly 1 cycle from in_valid sampled high to out_valid high, with the matching d and b.
- Throughput: 1 pair per cycle.
- All outputs are driven directly from flops, with no combinational path from input to output.
- Reset mid-stream: a pair sampled in the same edge as rst=1 is discarded. out_valid is 0 on the following cycle.
- First valid input after reset deasserts: that pair is accepted on the first edge with rst=0.
- borrow_cnt updates on the same edge that registers the corresponding b. A counter value of n is visible in the same cycle as the n-th borrow's out_valid.

## Configuration
- HALF_SUBTRACTOR_BORROW_CNT_EN defined:
  - The borrow_cnt port and its CNT_W-bit saturating counter are present, as described above.
- HALF_SUBTRACTOR_BORROW_CNT_EN not defined:
  - The borrow_cnt port and the counter logic are absent.
  - CNT_W has no effect.
  - d, b and out_valid behave identically in both builds.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, x=0, y=1 -> d=0, b=0, out_valid=0, borrow_cnt=0 throughout.
- Exhaustive table: apply back-to-back pairs (0,0), (0,1), (1,0), (1,1) with in_valid=1 -> one cycle later out_valid=1 on 4 consecutive cycles with (d,b) = (0,0), (1,1), (1,0), (0,0). borrow_cnt ends at 1.
- Hold on idle: accept (0,1), then in_valid=0 for 3 cycles -> out_valid=1 for one cycle then 0; d=1 and b=1 held for all 3 cycles.
- Reset mid-stream: accept (1,0), then assert rst in the same cycle as in_valid=1 with pair (0,1) -> after the edge d=0, b=0, out_valid=0; (0,1) is never output and borrow_cnt=0.
- Saturation (CNT_W=2, macro defined): 5 accepted (0,1) pairs -> borrow_cnt reads 1, 2, 3, 3, 3.
- Macro undefined build: repeat the exhaustive-table scenario -> identical d, b and out_valid waveforms, and no borrow_cnt port exists.
